// File: rtl/rob_pkg.sv
// Shared types and helpers for the reorder-buffer controller.
// Tag width derivation is centralised here so the interface and RTL agree.
package rob_pkg;

    localparam int AFULL_TH_DEFAULT = 2;

    typedef enum logic [1:0] {
        ERR_NONE,
        ERR_UNALLOC,
        ERR_DUP,
        ERR_RANGE
    } err_cause_e;

    // A single-entry buffer still needs one address bit.
    function automatic int tag_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/reorder_buff_ctrl_if.sv
// Issue / completion / retire signal bundle for the reorder-buffer controller.
// master drives requests and completions, slave is the controller.
interface reorder_buff_ctrl_if #(
    parameter int NUM_ENTRY = 6,
    parameter int NUM_WPORT = 2
) ();
    localparam int WIDTH_TAG = rob_pkg::tag_width(NUM_ENTRY);

    logic                                 I_Clr;
    logic                                 I_Alloc;
    logic [WIDTH_TAG-1:0]                 O_AllocTag;
    logic                                 O_AllocAck;
    logic [NUM_WPORT-1:0]                 I_We;
    logic [NUM_WPORT-1:0][WIDTH_TAG-1:0]  I_WTag;
    logic [WIDTH_TAG-1:0]                 O_RAddr;
    logic                                 O_RValid;
    logic                                 I_Re;
    logic                                 O_Full;
    logic                                 O_AFull;
    logic                                 O_Empty;
    logic [WIDTH_TAG:0]                   O_Count;
    logic                                 O_Err;

    modport master (
        output I_Clr, I_Alloc, I_We, I_WTag, I_Re,
        input  O_AllocTag, O_AllocAck, O_RAddr, O_RValid,
               O_Full, O_AFull, O_Empty, O_Count, O_Err
    );

    modport slave (
        input  I_Clr, I_Alloc, I_We, I_WTag, I_Re,
        output O_AllocTag, O_AllocAck, O_RAddr, O_RValid,
               O_Full, O_AFull, O_Empty, O_Count, O_Err
    );
endinterface

// File: rtl/rob_wrap_ptr.sv
// Modulo-N pointer: wraps explicitly from N-1 to 0, so N need not be a power of two.
// One-cycle update; clr beats inc.
module rob_wrap_ptr import rob_pkg::*; #(
    parameter int N = 6,
    parameter int W = tag_width(N)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] ptr
);
    localparam logic [W-1:0] LAST = W'(N - 1);

    logic [W-1:0] ptr_q, ptr_d;

    always_comb begin
        ptr_d = ptr_q;
        if (clr) begin
            ptr_d = '0;
        end else if (inc) begin
            ptr_d = (ptr_q == LAST) ? '0 : ptr_q + W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    assign ptr = ptr_q;
endmodule

// File: rtl/reorder_buff_ctrl.sv
// Reorder-buffer controller: in-order tag allocation, out-of-order completion, in-order retire.
// Completion to retire-ready is one cycle; allocation is refused while the registered count is full.
module reorder_buff_ctrl import rob_pkg::*; #(
    parameter int NUM_ENTRY = 6,
    parameter int NUM_WPORT = 2,
    parameter int AFULL_TH  = AFULL_TH_DEFAULT
) (
    input  logic                clock,
    input  logic                reset,
    reorder_buff_ctrl_if.slave  bus
);
    localparam int WIDTH_TAG = tag_width(NUM_ENTRY);
    localparam int CW        = WIDTH_TAG + 1;
    localparam logic [CW-1:0] DEPTH = CW'(NUM_ENTRY);

    logic [WIDTH_TAG-1:0] head, tail;
    logic [CW-1:0]        count_q, count_d;
    logic [NUM_ENTRY-1:0] alloc_q, alloc_d;
    logic [NUM_ENTRY-1:0] done_q, done_d;
    logic                 err_q, err_d;

    logic                 full, empty, alloc_ack, rvalid, retire;
    logic [CW-1:0]        free_cnt;
    logic [NUM_WPORT-1:0] wr_dup;

    rob_wrap_ptr #(.N(NUM_ENTRY), .W(WIDTH_TAG)) u_head (
        .clk(clock), .rst(reset), .clr(bus.I_Clr), .inc(retire), .ptr(head)
    );

    rob_wrap_ptr #(.N(NUM_ENTRY), .W(WIDTH_TAG)) u_tail (
        .clk(clock), .rst(reset), .clr(bus.I_Clr), .inc(alloc_ack), .ptr(tail)
    );

    always_comb begin
        full      = (count_q == DEPTH);
        empty     = (count_q == '0);
        free_cnt  = DEPTH - count_q;
        alloc_ack = bus.I_Alloc & ~full;
        rvalid    = ~empty & done_q[head];
        retire    = bus.I_Re & rvalid;
    end

    // A port is a duplicate if any lower-numbered port writes the same tag this cycle.
    always_comb begin
        wr_dup = '0;
        for (int p = 1; p < NUM_WPORT; p++) begin
            for (int q = 0; q < p; q++) begin
                if (bus.I_We[q] && bus.I_We[p] && (bus.I_WTag[q] == bus.I_WTag[p])) begin
                    wr_dup[p] = 1'b1;
                end
            end
        end
    end

    always_comb begin
        alloc_d = alloc_q;
        done_d  = done_q;
        err_d   = err_q;
        count_d = count_q;

        // Legality is judged against registered state, so a write to the retiring head is caught as already-done.
        for (int p = 0; p < NUM_WPORT; p++) begin
            if (bus.I_We[p]) begin
                if ({1'b0, bus.I_WTag[p]} >= DEPTH) begin
                    err_d = 1'b1;
                end else if (!alloc_q[bus.I_WTag[p]] || done_q[bus.I_WTag[p]] || wr_dup[p]) begin
                    err_d = 1'b1;
                end else begin
                    done_d[bus.I_WTag[p]] = 1'b1;
                end
            end
        end

        if (alloc_ack) begin
            alloc_d[tail] = 1'b1;
            done_d[tail]  = 1'b0;
        end
        if (retire) begin
            alloc_d[head] = 1'b0;
            done_d[head]  = 1'b0;
        end

        if (alloc_ack && !retire) begin
            count_d = count_q + CW'(1);
        end else if (!alloc_ack && retire) begin
            count_d = count_q - CW'(1);
        end

        if (bus.I_Clr) begin
            alloc_d = '0;
            done_d  = '0;
            err_d   = 1'b0;
            count_d = '0;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            count_q <= '0;
            alloc_q <= '0;
            done_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            count_q <= count_d;
            alloc_q <= alloc_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    assign bus.O_AllocTag = tail;
    assign bus.O_AllocAck = alloc_ack;
    assign bus.O_RAddr    = head;
    assign bus.O_RValid   = rvalid;
    assign bus.O_Full     = full;
    assign bus.O_AFull    = (int'(free_cnt) <= AFULL_TH);
    assign bus.O_Empty    = empty;
    assign bus.O_Count    = count_q;
    assign bus.O_Err      = err_q;
endmodule

// File: tb/tb_reorder_buff_ctrl.sv
// Directed bench for the reorder-buffer controller with a queue-based scoreboard.
// Stimulus pushes expected alloc tags and retire addresses; a negedge monitor pops and compares.
module tb_reorder_buff_ctrl;
    localparam int NE = 6;
    localparam int NW = 2;
    localparam int WT = 3;

    logic clock = 1'b0;
    logic reset;
    always #5 clock = ~clock;

    reorder_buff_ctrl_if #(.NUM_ENTRY(NE), .NUM_WPORT(NW)) bus ();

    reorder_buff_ctrl #(.NUM_ENTRY(NE), .NUM_WPORT(NW), .AFULL_TH(2)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    int n_cmp = 0;
    int n_err = 0;
    logic [WT-1:0] exp_alloc_q[$];
    logic [WT-1:0] exp_ret_q[$];
    bit range_mon = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, want %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic alloc_one(input logic [WT-1:0] tag);
        exp_alloc_q.push_back(tag);
        bus.I_Alloc = 1'b1;
        tick();
        bus.I_Alloc = 1'b0;
    endtask

    task automatic complete(input logic [NW-1:0] we, input logic [WT-1:0] t0, input logic [WT-1:0] t1);
        bus.I_We     = we;
        bus.I_WTag[0] = t0;
        bus.I_WTag[1] = t1;
        tick();
        bus.I_We = '0;
    endtask

    task automatic retire_one(input logic [WT-1:0] tag);
        exp_ret_q.push_back(tag);
        bus.I_Re = 1'b1;
        tick();
        bus.I_Re = 1'b0;
    endtask

    task automatic do_clr();
        bus.I_Clr = 1'b1;
        tick();
        bus.I_Clr = 1'b0;
    endtask

    // Scoreboard monitor: compares whenever an alloc ack or a retire is presented.
    always @(negedge clock) begin
        if (!reset && !bus.I_Clr) begin
            if (bus.O_AllocAck) begin
                if (exp_alloc_q.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL alloc_tag: unexpected ack with tag %0d, want no ack", bus.O_AllocTag);
                end else begin
                    chk("alloc_tag", 32'(bus.O_AllocTag), 32'(exp_alloc_q.pop_front()));
                end
            end
            if (bus.I_Re && bus.O_RValid) begin
                if (exp_ret_q.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL retire_addr: unexpected retire at %0d, want none", bus.O_RAddr);
                end else begin
                    chk("retire_addr", 32'(bus.O_RAddr), 32'(exp_ret_q.pop_front()));
                end
            end
            if (range_mon) begin
                chk("alloc_tag_range", 32'(bus.O_AllocTag < WT'(NE)), 32'd1);
                chk("raddr_range", 32'(bus.O_RAddr < WT'(NE)), 32'd1);
                chk("count_bound", 32'(bus.O_Count <= 4'(NE)), 32'd1);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, want normal completion");
        $fatal(1, "watchdog");
    end

    initial begin
        reset       = 1'b1;
        bus.I_Clr   = 1'b0;
        bus.I_Alloc = 1'b0;
        bus.I_We    = '0;
        bus.I_WTag  = '0;
        bus.I_Re    = 1'b0;
        tick();
        tick();
        reset = 1'b0;

        chk("rst_empty", 32'(bus.O_Empty), 32'd1);
        chk("rst_full", 32'(bus.O_Full), 32'd0);
        chk("rst_rvalid", 32'(bus.O_RValid), 32'd0);
        chk("rst_err", 32'(bus.O_Err), 32'd0);
        chk("rst_alloctag", 32'(bus.O_AllocTag), 32'd0);
        chk("rst_raddr", 32'(bus.O_RAddr), 32'd0);
        chk("rst_count", 32'(bus.O_Count), 32'd0);

        // Fill to capacity, then one refused allocation.
        for (int i = 0; i < NE; i++) alloc_one(WT'(i));
        chk("fill_count", 32'(bus.O_Count), 32'd6);
        chk("fill_full", 32'(bus.O_Full), 32'd1);
        chk("fill_afull", 32'(bus.O_AFull), 32'd1);
        bus.I_Alloc = 1'b1;
        #1;
        chk("full_ack", 32'(bus.O_AllocAck), 32'd0);
        tick();
        bus.I_Alloc = 1'b0;
        chk("full_count_hold", 32'(bus.O_Count), 32'd6);
        chk("full_no_err", 32'(bus.O_Err), 32'd0);
        do_clr();
        chk("clr_empty", 32'(bus.O_Empty), 32'd1);

        // Out-of-order completion, in-order retire.
        for (int i = 0; i < 3; i++) alloc_one(WT'(i));
        chk("afull_cnt3", 32'(bus.O_AFull), 32'd0);
        complete(2'b01, 3'd2, 3'd0);
        complete(2'b01, 3'd1, 3'd0);
        chk("ooo_rvalid_lo", 32'(bus.O_RValid), 32'd0);
        complete(2'b01, 3'd0, 3'd0);
        chk("ooo_rvalid_hi", 32'(bus.O_RValid), 32'd1);
        for (int i = 0; i < 3; i++) retire_one(WT'(i));
        chk("ooo_empty", 32'(bus.O_Empty), 32'd1);
        chk("ooo_no_err", 32'(bus.O_Err), 32'd0);

        // Dual-port completion and back-to-back retires; AFull threshold.
        do_clr();
        for (int i = 0; i < 3; i++) alloc_one(WT'(i));
        chk("afull_cnt3b", 32'(bus.O_AFull), 32'd0);
        alloc_one(3'd3);
        chk("afull_cnt4", 32'(bus.O_AFull), 32'd1);
        chk("cnt4", 32'(bus.O_Count), 32'd4);
        alloc_one(3'd4);
        complete(2'b11, 3'd0, 3'd1);
        complete(2'b01, 3'd2, 3'd0);
        for (int i = 0; i < 3; i++) retire_one(WT'(i));
        complete(2'b11, 3'd3, 3'd4);
        chk("dual_rvalid0", 32'(bus.O_RValid), 32'd1);
        retire_one(3'd3);
        chk("dual_rvalid1", 32'(bus.O_RValid), 32'd1);
        retire_one(3'd4);
        chk("dual_empty", 32'(bus.O_Empty), 32'd1);
        chk("dual_no_err", 32'(bus.O_Err), 32'd0);

        // Full with simultaneous alloc+retire: retire only, alloc next cycle. Head/tail at 5.
        alloc_one(3'd5);
        for (int i = 0; i < 5; i++) alloc_one(WT'(i));
        chk("wrapfill_full", 32'(bus.O_Full), 32'd1);
        complete(2'b11, 3'd5, 3'd0);
        bus.I_Alloc = 1'b1;
        exp_ret_q.push_back(3'd5);
        bus.I_Re = 1'b1;
        #1;
        chk("fullrr_ack", 32'(bus.O_AllocAck), 32'd0);
        tick();
        bus.I_Re = 1'b0;
        chk("fullrr_count", 32'(bus.O_Count), 32'd5);
        chk("fullrr_notfull", 32'(bus.O_Full), 32'd0);
        exp_alloc_q.push_back(3'd5);
        #1;
        chk("next_ack", 32'(bus.O_AllocAck), 32'd1);
        tick();
        bus.I_Alloc = 1'b0;
        chk("next_count", 32'(bus.O_Count), 32'd6);
        chk("next_rvalid", 32'(bus.O_RValid), 32'd1);
        do_clr();

        // Pipelined wrap: alloc k, complete k-1, retire k-2.
        range_mon = 1'b1;
        for (int k = 0; k < 22; k++) begin
            bus.I_Alloc = (k < 20);
            if (k < 20) exp_alloc_q.push_back(WT'(k % NE));
            bus.I_We      = (k >= 1 && k <= 20) ? 2'b01 : 2'b00;
            bus.I_WTag[0] = (k >= 1) ? WT'((k - 1) % NE) : '0;
            bus.I_Re      = (k >= 2);
            if (k >= 2) exp_ret_q.push_back(WT'((k - 2) % NE));
            tick();
        end
        bus.I_Alloc = 1'b0;
        bus.I_We    = '0;
        bus.I_Re    = 1'b0;
        range_mon   = 1'b0;
        chk("wrap_empty", 32'(bus.O_Empty), 32'd1);
        chk("wrap_no_err", 32'(bus.O_Err), 32'd0);

        // Error cases.
        do_clr();
        for (int i = 0; i < 3; i++) alloc_one(WT'(i));
        complete(2'b01, 3'd5, 3'd0);
        chk("err_unalloc", 32'(bus.O_Err), 32'd1);
        chk("err_unalloc_rvalid", 32'(bus.O_RValid), 32'd0);
        do_clr();
        chk("clr_err", 32'(bus.O_Err), 32'd0);
        chk("clr_empty2", 32'(bus.O_Empty), 32'd1);
        chk("clr_tag", 32'(bus.O_AllocTag), 32'd0);
        alloc_one(3'd0);
        complete(2'b11, 3'd0, 3'd0);
        chk("err_dup", 32'(bus.O_Err), 32'd1);
        chk("dup_done_once", 32'(bus.O_RValid), 32'd1);
        do_clr();
        alloc_one(3'd0);
        complete(2'b01, 3'd0, 3'd0);
        chk("single_ok", 32'(bus.O_Err), 32'd0);
        complete(2'b01, 3'd0, 3'd0);
        chk("err_redone", 32'(bus.O_Err), 32'd1);
        do_clr();
        complete(2'b10, 3'd0, 3'd6);
        chk("err_range", 32'(bus.O_Err), 32'd1);

        // Clear beats a same-cycle allocation.
        bus.I_Clr   = 1'b1;
        bus.I_Alloc = 1'b1;
        tick();
        bus.I_Clr   = 1'b0;
        bus.I_Alloc = 1'b0;
        chk("clrpri_count", 32'(bus.O_Count), 32'd0);
        chk("clrpri_tag", 32'(bus.O_AllocTag), 32'd0);
        chk("clrpri_err", 32'(bus.O_Err), 32'd0);
        alloc_one(3'd0);
        chk("post_clr_count", 32'(bus.O_Count), 32'd1);
        tick();

        chk("alloc_queue_drained", 32'(exp_alloc_q.size()), 32'd0);
        chk("retire_queue_drained", 32'(exp_ret_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
